ptp_bus_arb: RTL and testbench
==============================

Name: ptp_bus_arb

Overview:
- Two-master arbiter for the 32-bit bus2ip register bus of the xge-ptpv2 core.
- Master 0 is the host CPU bridge; master 1 is the internal timestamp/interrupt service engine.
- Serialises their single-word accesses onto one bus2ip_* slave interface, which feeds the interrupt controller, timestamp and config register blocks.
- Each access uses a fixed-length chip-enable window, followed by a mandatory chip-enable-low gap, so slave read-to-clear detection (falling edge of rd_ce) fires for every read.

Parameters:
- ACC_CYCLES, 2: cycles bus2ip_rd_ce_o / bus2ip_wr_ce_o are held high per access. Legal range is 1..15; the counter is 4 bits.

Ports:
- bus2ip_clk  in  1  clock
- bus2ip_rst_n  in  1  reset
- m0_req_i  in  1  master 0 request; held high until m0_ack_o
- m0_wr_i  in  1  1 = write, 0 = read
- m0_addr_i  in  32  access address
- m0_wdata_i  in  32  write data
- m0_ack_o  out  1  one-cycle completion pulse
- m0_rdata_o  out  32  read data; valid from the ack cycle and held until the next master 0 read ack
- m1_req_i, m1_wr_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o: same as master 0, for master 1
- bus2ip_addr_o  out  32  slave address
- bus2ip_data_o  out  32  slave write data
- bus2ip_rd_ce_o  out  1  slave read enable, active high
- bus2ip_wr_ce_o  out  1  slave write enable, active high
- ip2bus_data_i  in  32  combinational slave read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset and clock: reset bus2ip_rst_n, asynchronous, active-low; clock bus2ip_clk.
- Reset values:
  - All outputs 0; state IDLE; access counter 0.
  - rr_last = 1, so master 0 wins the first tie.
- FSM has three states: IDLE, ACCESS, ACK. All bus2ip_* outputs are registered.
- IDLE:
  - No req high: stay; ce outputs 0; addr/data outputs hold last values.
  - Exactly one req high: grant that master.
  - Both high: grant the master != rr_last (round robin).
  - On grant: latch sel, wr, addr, wdata; set rr_last = sel; load cnt = ACC_CYCLES-1; go to ACCESS.
- ACCESS:
  - bus2ip_addr_o / bus2ip_data_o = latched values.
  - bus2ip_rd_ce_o = ~wr and bus2ip_wr_ce_o = wr, high for exactly ACC_CYCLES consecutive cycles, starting the cycle after the grant.
  - Decrement cnt each cycle.
  - On the cycle cnt == 0 with a read: capture ip2bus_data_i into the selected master's rdata register. Go to ACK.
- ACK:
  - Both ce outputs 0; address held.
  - Selected master's ack_o = 1 for this single cycle; rdata_o is valid this cycle.
  - Go to IDLE. A new grant can occur in that IDLE cycle, so ce is low for at least 2 cycles between accesses.
- Latency:
  - Request in IDLE at cycle t: ce high t+1 .. t+ACC_CYCLES; ack at t+ACC_CYCLES+1.
  - Minimum issue period is ACC_CYCLES+2 cycles.
- Write ack leaves rdata_o unchanged. The non-selected master's rdata_o is never modified.
- Request fields are sampled only at grant; later changes are ignored.
- A master that drops req before its ack still gets its access completed and acked. A req held after ack is treated as a new request.
- Starvation-free: with both masters requesting continuously, grants strictly alternate.
- Reset mid-access: ce outputs drop to 0 asynchronously, no ack is issued, and the transaction is lost.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2)
  - INT_BASE_ADDR = 32'h300 and INT_MASK_ADDR = 32'h301, for benches and software map
- Sub-module ptp_rr_arb2:
  - combinational 2-way round-robin picker
  - inputs: req[1:0], rr_last; outputs: gnt_valid, gnt_sel

Test Plan:
- Single read: ACC_CYCLES=2, m0 reads 0x300 at cycle 0 with status 4'b0101 pending. Expect rd_ce_o high cycles 1-2, m0_ack_o at cycle 3 with m0_rdata_o = 0x5, and status reading 0 afterwards (read-clear fired).
- Simultaneous requests: m0 and m1 raise req together after reset. Expect m0 granted first, m1 next; with both held, grant order m0, m1, m0, m1 and an ack every 4 cycles.
- Write: m1 writes 0x0000000A to 0x301. Expect wr_ce_o high 2 cycles with data 0xA; a subsequent m0 read of 0x301 returns 0xA; m1_rdata_o unchanged.
- Back-to-back same-address reads: m0 then m1 both read 0x300 with a status bit set between the accesses. Expect ce low for at least 2 cycles between windows, a separate read-clear per access, and m1 seeing only the newly set bit.
- Edge parameters: ACC_CYCLES=1 gives a one-cycle ce and ack 2 cycles after the grant; ACC_CYCLES=15 gives a 15-cycle ce window.
- Reset mid-access: assert bus2ip_rst_n low during ACCESS cycle 1. Expect ce outputs 0 immediately, no ack, busy_o=0, and m0 winning the next tie.

Source files
------------

// File: rtl/ptp_bus_arb_pkg.sv
// Shared definitions for the ptpv2 bus2ip two-master arbiter slice.
package ptp_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [31:0] INT_BASE_ADDR = 32'h0000_0300;
  localparam logic [31:0] INT_MASK_ADDR = 32'h0000_0301;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ptp_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the master that did not win last time is chosen.
module ptp_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic       gnt_valid_o,
  output logic       gnt_sel_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_sel_o   = 1'b0;
    if (&req_i) gnt_sel_o = ~rr_last_i;
    else        gnt_sel_o = req_i[1];
  end

endmodule

// File: rtl/ptp_bus_arb.sv
// Two-master arbiter serialising single-word accesses onto the bus2ip slave bus
// with a fixed chip-enable window followed by a chip-enable-low gap.
module ptp_bus_arb #(
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst_n,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus2ip_addr_o,
  output logic [31:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic [31:0] ip2bus_data_i,
  output logic        busy_o
);
  import ptp_bus_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             wr_q, wr_d;
  logic             rr_last_q, rr_last_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             rd_ce_q, rd_ce_d;
  logic             wr_ce_q, wr_ce_d;
  logic             m0_ack_q, m0_ack_d;
  logic             m1_ack_q, m1_ack_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  logic gnt_valid;
  logic gnt_sel;

  ptp_rr_arb2 u_rr_arb2 (
    .req_i       ({m1_req_i, m0_req_i}),
    .rr_last_i   (rr_last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    rr_last_d  = rr_last_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_ce_d    = 1'b0;
    wr_ce_d    = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          sel_d     = gnt_sel;
          wr_d      = gnt_sel ? m1_wr_i    : m0_wr_i;
          addr_d    = gnt_sel ? m1_addr_i  : m0_addr_i;
          data_d    = gnt_sel ? m1_wdata_i : m0_wdata_i;
          rr_last_d = gnt_sel;
          cnt_d     = CNT_LOAD;
          rd_ce_d   = ~wr_d;
          wr_ce_d   = wr_d;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // ce is registered, so the last window cycle is the one where cnt_q hits 0
        if (cnt_q == '0) begin
          m0_ack_d = ~sel_q;
          m1_ack_d = sel_q;
          if (!wr_q) begin
            if (sel_q) m1_rdata_d = ip2bus_data_i;
            else       m0_rdata_d = ip2bus_data_i;
          end
          state_d = ACK;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          rd_ce_d = ~wr_q;
          wr_ce_d = wr_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      rd_ce_q    <= 1'b0;
      wr_ce_q    <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      rr_last_q  <= rr_last_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_ce_q    <= rd_ce_d;
      wr_ce_q    <= wr_ce_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign bus2ip_addr_o  = addr_q;
  assign bus2ip_data_o  = data_q;
  assign bus2ip_rd_ce_o = rd_ce_q;
  assign bus2ip_wr_ce_o = wr_ce_q;
  assign m0_ack_o       = m0_ack_q;
  assign m1_ack_o       = m1_ack_q;
  assign m0_rdata_o     = m0_rdata_q;
  assign m1_rdata_o     = m1_rdata_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ptp_bus_arb.sv
// Self-checking bench for ptp_bus_arb with a read-to-clear slave model and an ack scoreboard.
module tb_ptp_bus_arb;
  import ptp_bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_drop = 1'b1, m1_drop = 1'b1;
  logic        m0_ack, m1_ack, b_rd_ce, b_wr_ce, busy;
  logic [31:0] m0_rdata, m1_rdata, b_addr, b_data, ip_data;

  logic        e_req = 1'b0;
  logic [31:0] e_addr = 32'h40;
  logic        e1_ack, e1_m1_ack, e1_rd, e1_wr, e1_busy;
  logic [31:0] e1_rdata, e1_m1_rdata, e1_addr, e1_data;
  logic        e15_ack, e15_m1_ack, e15_rd, e15_wr, e15_busy;
  logic [31:0] e15_rdata, e15_m1_rdata, e15_addr, e15_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ptp_bus_arb #(.ACC_CYCLES(2)) dut (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n),
    .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .bus2ip_addr_o(b_addr), .bus2ip_data_o(b_data),
    .bus2ip_rd_ce_o(b_rd_ce), .bus2ip_wr_ce_o(b_wr_ce),
    .ip2bus_data_i(ip_data), .busy_o(busy)
  );

  ptp_bus_arb #(.ACC_CYCLES(1)) u_e1 (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n),
    .m0_req_i(e_req), .m0_wr_i(1'b0), .m0_addr_i(e_addr), .m0_wdata_i(32'h0),
    .m0_ack_o(e1_ack), .m0_rdata_o(e1_rdata),
    .m1_req_i(1'b0), .m1_wr_i(1'b0), .m1_addr_i(32'h0), .m1_wdata_i(32'h0),
    .m1_ack_o(e1_m1_ack), .m1_rdata_o(e1_m1_rdata),
    .bus2ip_addr_o(e1_addr), .bus2ip_data_o(e1_data),
    .bus2ip_rd_ce_o(e1_rd), .bus2ip_wr_ce_o(e1_wr),
    .ip2bus_data_i(32'h0000_00E1), .busy_o(e1_busy)
  );

  ptp_bus_arb #(.ACC_CYCLES(15)) u_e15 (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n),
    .m0_req_i(e_req), .m0_wr_i(1'b0), .m0_addr_i(e_addr), .m0_wdata_i(32'h0),
    .m0_ack_o(e15_ack), .m0_rdata_o(e15_rdata),
    .m1_req_i(1'b0), .m1_wr_i(1'b0), .m1_addr_i(32'h0), .m1_wdata_i(32'h0),
    .m1_ack_o(e15_m1_ack), .m1_rdata_o(e15_m1_rdata),
    .bus2ip_addr_o(e15_addr), .bus2ip_data_o(e15_data),
    .bus2ip_rd_ce_o(e15_rd), .bus2ip_wr_ce_o(e15_wr),
    .ip2bus_data_i(32'h0000_00EF), .busy_o(e15_busy)
  );

  // Slave: status at INT_BASE_ADDR clears the bits it returned on the falling edge of rd_ce
  logic [31:0] status_q = '0, mask_q = '0, snap_q = '0;
  logic        rd_d1 = 1'b0;
  logic [31:0] set_cyc = 32'hFFFF_FFFF;
  logic [31:0] set_val = '0;

  always_comb begin
    if (b_addr == INT_BASE_ADDR)      ip_data = status_q;
    else if (b_addr == INT_MASK_ADDR) ip_data = mask_q;
    else                              ip_data = {16'hA5A5, b_addr[15:0]};
  end

  always @(posedge clk) begin
    rd_d1 <= b_rd_ce;
    if (b_rd_ce) snap_q <= status_q;
    if (b_wr_ce && b_addr == INT_MASK_ADDR) mask_q <= b_data;
    status_q <= (status_q & ~((rd_d1 && !b_rd_ce && b_addr == INT_BASE_ADDR) ? snap_q : 32'h0))
              | ((cyc == set_cyc) ? set_val : 32'h0);
  end

  typedef struct packed {
    logic        m;
    logic [31:0] rdata;
    logic [31:0] other;
    logic [31:0] cyc;
  } ack_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] start;
    logic [31:0] len;
    logic [31:0] addr;
    logic [31:0] data;
  } win_t;

  ack_t        exp_q[$];
  ack_t        obs_q[$];
  win_t        win_q[$];
  win_t        cur_q = '0;
  logic        ce_prev = 1'b0;
  int          n_dual = 0;
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin
    if (m0_ack && m1_ack) n_dual <= n_dual + 1;
    if (m0_ack) obs_q.push_back('{1'b0, m0_rdata, m1_rdata, cyc});
    if (m1_ack) obs_q.push_back('{1'b1, m1_rdata, m0_rdata, cyc});
    if ((b_rd_ce || b_wr_ce) && !ce_prev) cur_q <= '{b_wr_ce, cyc, 32'd1, b_addr, b_data};
    else if (b_rd_ce || b_wr_ce)          cur_q.len <= cur_q.len + 1;
    if (!(b_rd_ce || b_wr_ce) && ce_prev) win_q.push_back(cur_q);
    ce_prev <= b_rd_ce || b_wr_ce;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic m, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic drop);
    if (!m) begin m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d; m0_drop = drop; end
    else    begin m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d; m1_drop = drop; end
  endtask

  task automatic push_exp(input logic m, input logic wr, input logic [31:0] rd, input logic [31:0] c);
    if (!wr) m_rd[m] = rd;
    exp_q.push_back('{m, m_rd[m], m_rd[!m], c});
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) begin
      @(negedge clk); #1;
      if (m0_ack && m0_drop) m0_req = 1'b0;
      if (m1_ack && m1_drop) m1_req = 1'b0;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); win_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({m0_ack, m1_ack, b_rd_ce, b_wr_ce, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b, required 00000", {m0_ack, m1_ack, b_rd_ce, b_wr_ce, busy});
    end
    n_checks++;
    if ({m0_rdata, m1_rdata, b_addr, b_data} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h, required all 0", m0_rdata, m1_rdata, b_addr, b_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, b_rd_ce, b_wr_ce} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, required 000", {busy, b_rd_ce, b_wr_ce});
    end
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic test_single_read();
    logic [31:0] t0;
    ack_t e, o;
    win_t w;
    clear_sb();
    @(negedge clk); #1;
    set_cyc = cyc; set_val = 32'h5;
    issue(1'b0, 1'b0, INT_BASE_ADDR, 32'h0, 1'b1);
    t0 = cyc;
    push_exp(1'b0, 1'b0, 32'h5, t0 + 3);
    wait_acks(1, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sr_ack: no ack seen, required m%0d rdata %h at cycle %0d", e.m, e.rdata, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL sr_ack: got m%0d rdata %h other %h cyc %0d, required m%0d rdata %h other %h cyc %0d",
                             o.m, o.rdata, o.other, o.cyc, e.m, e.rdata, e.other, e.cyc);
        end
      end
    end
    n_checks++;
    if (win_q.size() == 0) begin
      n_fail++; $display("FAIL sr_window: no ce window seen");
    end else begin
      w = win_q.pop_front();
      if (w.wr !== 1'b0 || w.start !== t0 + 1 || w.len !== 32'd2 || w.addr !== INT_BASE_ADDR) begin
        n_fail++; $display("FAIL sr_window: got wr %b start %0d len %0d addr %h, required wr 0 start %0d len 2 addr %h",
                           w.wr, w.start, w.len, w.addr, t0 + 1, INT_BASE_ADDR);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (status_q !== 32'h0) begin
      n_fail++; $display("FAIL sr_read_clear: status got %h, required 0", status_q);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] t0;
    ack_t e, o;
    win_t w;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    m_rd[0] = '0; m_rd[1] = '0;
    clear_sb();
    @(negedge clk); #1;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 1'b0, 32'hA5A5_0010, t0 + 3 + 4 * k);
      else            push_exp(1'b1, 1'b0, 32'hA5A5_0020, t0 + 3 + 4 * k);
    end
    wait_acks(4, 40);
    m0_req = 1'b0; m1_req = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rr_ack: no ack seen, required m%0d rdata %h at cycle %0d", e.m, e.rdata, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL rr_ack: got m%0d rdata %h other %h cyc %0d, required m%0d rdata %h other %h cyc %0d",
                             o.m, o.rdata, o.other, o.cyc, e.m, e.rdata, e.other, e.cyc);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (win_q.size() == 0) begin
        n_fail++; $display("FAIL rr_window%0d: no ce window seen", k);
      end else begin
        w = win_q.pop_front();
        if (w.wr !== 1'b0 || w.start !== t0 + 1 + 4 * k || w.len !== 32'd2 ||
            w.addr !== ((k % 2 == 0) ? 32'h10 : 32'h20)) begin
          n_fail++; $display("FAIL rr_window%0d: got wr %b start %0d len %0d addr %h, required wr 0 start %0d len 2 addr %h",
                             k, w.wr, w.start, w.len, w.addr, t0 + 1 + 4 * k, (k % 2 == 0) ? 32'h10 : 32'h20);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] t0;
    ack_t e, o;
    win_t w;
    clear_sb();
    repeat (2) @(negedge clk);
    #1;
    issue(1'b1, 1'b1, INT_MASK_ADDR, 32'h0000_000A, 1'b1);
    t0 = cyc;
    push_exp(1'b1, 1'b1, 32'h0, t0 + 3);
    @(negedge clk); #1;
    m1_addr = 32'h0000_0BAD; m1_wdata = 32'hFFFF_FFFF;
    wait_acks(1, 20);
    @(negedge clk); #1;
    issue(1'b0, 1'b0, INT_MASK_ADDR, 32'h0, 1'b1);
    push_exp(1'b0, 1'b0, 32'h0000_000A, cyc + 3);
    wait_acks(2, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL wr_ack: no ack seen, required m%0d rdata %h at cycle %0d", e.m, e.rdata, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL wr_ack: got m%0d rdata %h other %h cyc %0d, required m%0d rdata %h other %h cyc %0d",
                             o.m, o.rdata, o.other, o.cyc, e.m, e.rdata, e.other, e.cyc);
        end
      end
    end
    n_checks++;
    if (win_q.size() == 0) begin
      n_fail++; $display("FAIL wr_window: no ce window seen");
    end else begin
      w = win_q.pop_front();
      if (w.wr !== 1'b1 || w.start !== t0 + 1 || w.len !== 32'd2 || w.addr !== INT_MASK_ADDR || w.data !== 32'hA) begin
        n_fail++; $display("FAIL wr_window: got wr %b start %0d len %0d addr %h data %h, required wr 1 start %0d len 2 addr %h data 0000000a",
                           w.wr, w.start, w.len, w.addr, w.data, t0 + 1, INT_MASK_ADDR);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t0;
    ack_t e, o;
    win_t w1, w2;
    clear_sb();
    @(negedge clk); #1;
    set_cyc = cyc; set_val = 32'h1;
    @(negedge clk); #1;
    issue(1'b0, 1'b0, INT_BASE_ADDR, 32'h0, 1'b1);
    t0 = cyc;
    set_cyc = t0 + 4; set_val = 32'h4;
    push_exp(1'b0, 1'b0, 32'h1, t0 + 3);
    push_exp(1'b1, 1'b0, 32'h4, t0 + 7);
    @(negedge clk); #1;
    issue(1'b1, 1'b0, INT_BASE_ADDR, 32'h0, 1'b1);
    wait_acks(2, 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_ack: no ack seen, required m%0d rdata %h at cycle %0d", e.m, e.rdata, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL b2b_ack: got m%0d rdata %h other %h cyc %0d, required m%0d rdata %h other %h cyc %0d",
                             o.m, o.rdata, o.other, o.cyc, e.m, e.rdata, e.other, e.cyc);
        end
      end
    end
    n_checks++;
    if (win_q.size() < 2) begin
      n_fail++; $display("FAIL b2b_gap: got %0d ce windows, required 2", win_q.size());
    end else begin
      w1 = win_q.pop_front(); w2 = win_q.pop_front();
      if (w1.start !== t0 + 1 || w2.start !== t0 + 5 || w1.len !== 32'd2 || w2.len !== 32'd2 ||
          (w2.start - w1.start - w1.len) < 32'd2) begin
        n_fail++; $display("FAIL b2b_gap: got starts %0d/%0d lens %0d/%0d, required starts %0d/%0d lens 2/2 gap >= 2",
                           w1.start, w2.start, w1.len, w2.len, t0 + 1, t0 + 5);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (status_q !== 32'h0) begin
      n_fail++; $display("FAIL b2b_read_clear: status got %h, required 0", status_q);
    end
  endtask

  task automatic test_edge_params();
    logic [31:0] t0;
    int          ce1_n, ce15_n, ack1_n, ack15_n;
    logic [31:0] ce1_first, ce15_first, ce15_last, ack1_cyc, ack15_cyc, r1, r15;
    ce1_n = 0; ce15_n = 0; ack1_n = 0; ack15_n = 0;
    ce1_first = '1; ce15_first = '1; ce15_last = '0; ack1_cyc = '0; ack15_cyc = '0; r1 = '0; r15 = '0;
    @(negedge clk); #1;
    e_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk); #1;
      if (e1_rd)  begin ce1_n++;  if (ce1_first == '1) ce1_first = cyc; end
      if (e15_rd) begin ce15_n++; if (ce15_first == '1) ce15_first = cyc; ce15_last = cyc; end
      if (e1_ack)  begin ack1_n++;  ack1_cyc = cyc;  r1 = e1_rdata;  e_req = 1'b0; end
      if (e15_ack) begin ack15_n++; ack15_cyc = cyc; r15 = e15_rdata; end
    end
    n_checks++;
    if (ce1_n != 1 || ce1_first !== t0 + 1) begin
      n_fail++; $display("FAIL edge1_ce: got %0d cycles from %0d, required 1 cycle at %0d", ce1_n, ce1_first, t0 + 1);
    end
    n_checks++;
    if (ack1_n != 1 || ack1_cyc !== t0 + 2 || r1 !== 32'hE1) begin
      n_fail++; $display("FAIL edge1_ack: got %0d acks at %0d rdata %h, required 1 at %0d rdata 000000e1",
                         ack1_n, ack1_cyc, r1, t0 + 2);
    end
    n_checks++;
    if (ce15_n != 15 || ce15_first !== t0 + 1 || ce15_last !== t0 + 15) begin
      n_fail++; $display("FAIL edge15_ce: got %0d cycles %0d..%0d, required 15 cycles %0d..%0d",
                         ce15_n, ce15_first, ce15_last, t0 + 1, t0 + 15);
    end
    n_checks++;
    if (ack15_n != 1 || ack15_cyc !== t0 + 16 || r15 !== 32'hEF) begin
      n_fail++; $display("FAIL edge15_ack: got %0d acks at %0d rdata %h, required 1 at %0d rdata 000000ef",
                         ack15_n, ack15_cyc, r15, t0 + 16);
    end
    n_checks++;
    if ({e1_m1_ack, e15_m1_ack, e1_wr, e15_wr, e1_busy, e15_busy} !== 6'b0 ||
        {e1_m1_rdata, e15_m1_rdata, e1_data, e15_data} !== 128'h0 || e1_addr !== 32'h40 || e15_addr !== 32'h40) begin
      n_fail++; $display("FAIL edge_quiet: got ctl %b addr %h/%h, required ctl 000000 addr 00000040/00000040",
                         {e1_m1_ack, e15_m1_ack, e1_wr, e15_wr, e1_busy, e15_busy}, e1_addr, e15_addr);
    end
  endtask

  task automatic test_reset_mid_access();
    ack_t e, o;
    clear_sb();
    @(negedge clk); #1;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    @(negedge clk); #1;
    n_checks++;
    if (b_rd_ce !== 1'b1) begin
      n_fail++; $display("FAIL rm_ce_before: rd_ce got %b, required 1", b_rd_ce);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b_rd_ce, b_wr_ce, busy, m0_ack, m1_ack} !== 5'b0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_async: got ctl %b m0_rdata %h, required ctl 00000 m0_rdata 0",
                         {b_rd_ce, b_wr_ce, busy, m0_ack, m1_ack}, m0_rdata);
    end
    m0_req = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rm_no_ack: got %0d acks after reset, required 0", obs_q.size());
    end
    clear_sb();
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    push_exp(1'b0, 1'b0, 32'hA5A5_0010, cyc + 3);
    push_exp(1'b1, 1'b0, 32'hA5A5_0020, cyc + 7);
    wait_acks(2, 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rm_tie_ack: no ack seen, required m%0d rdata %h at cycle %0d", e.m, e.rdata, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL rm_tie_ack: got m%0d rdata %h other %h cyc %0d, required m%0d rdata %h other %h cyc %0d",
                             o.m, o.rdata, o.other, o.cyc, e.m, e.rdata, e.other, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || n_dual != 0) begin
      n_fail++; $display("FAIL spurious_ack: got %0d extra acks and %0d dual acks, required 0 and 0", obs_q.size(), n_dual);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write();
    test_back_to_back();
    test_edge_params();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
